// File: rtl/mtl2_lcd_pkg.sv
// Shared types and panel geometry for the MTL2 LCD output stage.
package mtl2_lcd_pkg;

    localparam int MTL2_H_ACTIVE = 800;
    localparam int MTL2_V_ACTIVE = 480;
    localparam int X_W           = 10;
    localparam int Y_W           = 9;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } cursor_t;

endpackage

// File: rtl/mtl2_xy_tracker.sv
// Pixel coordinate reconstruction from datavalid / v_sync edges, with sticky
// geometry-overflow detection.
module mtl2_xy_tracker
    import mtl2_lcd_pkg::*;
#(
    parameter int H_ACTIVE = MTL2_H_ACTIVE,
    parameter int V_ACTIVE = MTL2_V_ACTIVE
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           datavalid,
    input  logic           v_sync,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           frame_start,
    output logic           geom_err
);

    localparam logic [X_W-1:0] X_LIM  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LIM  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    logic           dv_d;
    logic           vs_d;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           line_end;
    logic           x_over;
    logic           y_over;

    // Counters may reach the active size; that value means "already at the last
    // column/row" and a further pixel or line is a geometry error.
    assign frame_start = vs_d & ~v_sync;
    assign line_end    = dv_d & ~datavalid;
    assign x_over      = datavalid && (x_cnt == X_LIM);
    assign y_over      = line_end && !frame_start && (y_cnt == Y_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_d     <= 1'b0;
            vs_d     <= 1'b1;
            x_cnt    <= '0;
            y_cnt    <= '0;
            geom_err <= 1'b0;
        end else begin
            dv_d <= datavalid;
            vs_d <= v_sync;
            if (line_end)
                x_cnt <= '0;
            else if (datavalid && !x_over)
                x_cnt <= x_cnt + 1'b1;
            if (frame_start)
                y_cnt <= '0;
            else if (line_end && !y_over)
                y_cnt <= y_cnt + 1'b1;
            if (x_over || y_over)
                geom_err <= 1'b1;
        end
    end

    assign x = (x_cnt >= X_LIM) ? X_LAST : x_cnt;
    assign y = (y_cnt >= Y_LIM) ? Y_LAST : y_cnt;

endmodule

// File: rtl/mtl2_lcd_out.sv
// MTL2 panel output stage: 2-cycle pipeline, optional crosshair overlay
// (MTL2_LCD_CURSOR_EN), underflow counter and geometry error flag.
module mtl2_lcd_out
    import mtl2_lcd_pkg::*;
#(
    parameter int          H_ACTIVE  = MTL2_H_ACTIVE,
    parameter int          V_ACTIVE  = MTL2_V_ACTIVE,
    parameter int          CUR_HALF  = 8,
    parameter logic [23:0] CUR_COLOR = 24'hFFFFFF
) (
    input  logic        vid_clk,
    input  logic        reset_n,
    input  logic [23:0] vid_data,
    input  logic        vid_datavalid,
    input  logic        vid_h_sync,
    input  logic        vid_v_sync,
    input  logic        vid_underflow,
    input  logic [9:0]  cursor_x,
    input  logic [8:0]  cursor_y,
    input  logic        cursor_valid,
    output logic        cursor_ready,
    input  logic        cursor_on,
    input  logic        underflow_clr,
    output logic [7:0]  lcd_r,
    output logic [7:0]  lcd_g,
    output logic [7:0]  lcd_b,
    output logic        lcd_de,
    output logic        lcd_hsd,
    output logic        lcd_vsd,
    output logic [15:0] underflow_cnt,
    output logic        geom_err
);

    localparam logic signed [10:0] HALF_S = 11'(CUR_HALF);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
        return (v < 0) ? -v : v;
    endfunction

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           frame_start;
    logic           hit_p0;

    mtl2_xy_tracker #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE)
    ) u_xy (
        .clk        (vid_clk),
        .rst_n      (reset_n),
        .datavalid  (vid_datavalid),
        .v_sync     (vid_v_sync),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .geom_err   (geom_err)
    );

`ifdef MTL2_LCD_CURSOR_EN
    cursor_t                pend_cur;
    cursor_t                act_cur;
    logic                   pend_full;
    logic                   accept;
    logic signed [10:0]     dx_p0;
    logic signed [10:0]     dy_p0;

    assign cursor_ready = !pend_full;
    assign accept       = cursor_valid & !pend_full;

    // A request accepted on the frame-start cycle stays pending for the next frame.
    always_ff @(posedge vid_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_full <= 1'b0;
            pend_cur  <= '0;
            act_cur   <= '0;
        end else begin
            if (frame_start && pend_full)
                act_cur <= pend_cur;
            if (accept) begin
                pend_cur  <= '{x: cursor_x, y: cursor_y};
                pend_full <= 1'b1;
            end else if (frame_start) begin
                pend_full <= 1'b0;
            end
        end
    end

    assign dx_p0  = $signed({1'b0, x}) - $signed({1'b0, act_cur.x});
    assign dy_p0  = $signed({2'b00, y}) - $signed({2'b00, act_cur.y});
    assign hit_p0 = ((dx_p0 == 0 && abs11(dy_p0) <= HALF_S) ||
                     (dy_p0 == 0 && abs11(dx_p0) <= HALF_S)) &&
                    cursor_on && vid_datavalid;
`else
    logic cursor_unused;
    assign cursor_unused = ^{cursor_x, cursor_y, cursor_valid, cursor_on, x, y,
                             frame_start, HALF_S};
    assign cursor_ready  = 1'b1;
    assign hit_p0        = 1'b0;
`endif

    // Stage 1: registered pixel, syncs and overlay decision
    rgb_t data_p1;
    logic vld_p1;
    logic hsd_p1;
    logic vsd_p1;
    logic hit_p1;

    always_ff @(posedge vid_clk) begin
        data_p1 <= vid_data;
    end

    always_ff @(posedge vid_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            hsd_p1 <= 1'b1;
            vsd_p1 <= 1'b1;
            hit_p1 <= 1'b0;
        end else begin
            vld_p1 <= vid_datavalid;
            hsd_p1 <= vid_h_sync;
            vsd_p1 <= vid_v_sync;
            hit_p1 <= hit_p0;
        end
    end

    // Stage 2: colour mux with blanking, panel pins
    rgb_t rgb_p2;
    logic vld_p2;
    logic hsd_p2;
    logic vsd_p2;

    always_ff @(posedge vid_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_p2 <= '0;
            vld_p2 <= 1'b0;
            hsd_p2 <= 1'b1;
            vsd_p2 <= 1'b1;
        end else begin
            rgb_p2 <= !vld_p1 ? rgb_t'(24'h0) : (hit_p1 ? rgb_t'(CUR_COLOR) : data_p1);
            vld_p2 <= vld_p1;
            hsd_p2 <= hsd_p1;
            vsd_p2 <= vsd_p1;
        end
    end

    assign lcd_r   = rgb_p2.r;
    assign lcd_g   = rgb_p2.g;
    assign lcd_b   = rgb_p2.b;
    assign lcd_de  = vld_p2;
    assign lcd_hsd = hsd_p2;
    assign lcd_vsd = vsd_p2;

    always_ff @(posedge vid_clk or negedge reset_n) begin
        if (!reset_n)
            underflow_cnt <= '0;
        else if (underflow_clr)
            underflow_cnt <= '0;
        else if (vid_underflow)
            underflow_cnt <= sat_inc(underflow_cnt);
    end

endmodule
